// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared encodings for the MIPS debug loader path
package mips_dbg_pkg;

  localparam int NB_BYTE = 8;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - big-endian byte-to-word assembler (4 bytes per word)
module word_assembler
  import mips_dbg_pkg::*;
#(
  parameter int NB_WORD = 4 * NB_BYTE
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_WORD-1:0] o_word,
  output logic               o_word_valid
);

  logic [NB_WORD-NB_BYTE-1:0] r_shift;
  logic [1:0]                 r_idx;

  // The fourth byte is forwarded combinationally so the word is ready on the same edge.
  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_en && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_shift <= '0;
      r_idx   <= 2'd0;
    end else if (i_en) begin
      r_shift <= {r_shift[NB_WORD-2*NB_BYTE-1:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART-driven instruction loader and pipeline halt control
// Optional inter-byte timeout in LOAD is enabled by defining LOADER_TIMEOUT_EN.
module instr_loader
  import mips_dbg_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_COUNT = 8
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_pipe_halted,
  output logic                o_we_IF,
  output logic [NB_DATA-1:0]  o_instruction_data,
  output logic                o_halt,
  output logic                o_pipe_rst,
  output logic [NB_COUNT-1:0] o_instr_count,
  output logic                o_load_done,
  output logic                o_error,
  output logic [2:0]          o_state
);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [NB_DATA-1:0]  r_data;
  logic                r_halt;
  logic                r_pipe_rst;
  logic [NB_COUNT-1:0] r_count;
  logic                r_load_done;
  logic                r_error;

  logic                w_asm_en;
  logic                w_asm_clr;
  logic [NB_DATA-1:0]  w_word;
  logic                w_word_valid;
  logic                w_load_start;
  logic                w_word_wr;
  logic                w_halt_seen;
  logic                w_overflow;
  logic                w_timeout;

  word_assembler #(.NB_WORD(NB_DATA)) u_asm (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_clr        (w_asm_clr),
    .i_en         (w_asm_en),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (i_rst || (r_state != ST_LOAD) || i_rx_valid) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + 32'd1;
  end
`endif

  always_comb begin
    w_next       = r_state;
    w_asm_en     = 1'b0;
    w_asm_clr    = 1'b0;
    w_load_start = 1'b0;
    w_word_wr    = 1'b0;
    w_halt_seen  = 1'b0;
    w_overflow   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            w_next       = ST_LOAD;
            w_asm_clr    = 1'b1;
            w_load_start = 1'b1;
          end else if (i_rx_data == CMD_RUN && r_load_done) begin
            w_next = ST_RUN;
          end else if (i_rx_data == CMD_STEP && r_load_done) begin
            w_next = ST_STEP;
          end
        end
      end
      ST_LOAD: begin
        w_asm_en = i_rx_valid;
        if (w_word_valid) begin
          w_next    = ST_WRITE;
          w_word_wr = 1'b1;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (!i_rx_valid && r_to_cnt == TO_LAST) begin
          w_next    = ST_IDLE;
          w_asm_clr = 1'b1;
          w_timeout = 1'b1;
        end
`endif
      end
      ST_WRITE: begin
        // A byte landing here already belongs to the next word.
        w_asm_en = i_rx_valid;
        if (r_data == HALT_WORD) begin
          w_next      = ST_IDLE;
          w_halt_seen = 1'b1;
        end else if (r_count == '0) begin
          w_next     = ST_IDLE;
          w_overflow = 1'b1;
        end else begin
          w_next = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (i_pipe_halted) w_next = ST_IDLE;
      end
      ST_STEP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_data      <= '0;
      r_halt      <= 1'b1;
      r_pipe_rst  <= 1'b0;
      r_count     <= '0;
      r_load_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_we       <= w_word_wr;
      r_pipe_rst <= w_load_start;
      // Halt sense is taken on the entry edge so a step into a halted pipe stays frozen.
      r_halt     <= !((w_next == ST_RUN) || (w_next == ST_STEP && !i_pipe_halted));
      if (w_word_wr) begin
        r_data  <= w_word;
        r_count <= r_count + 1'b1;
      end
      if (w_load_start) begin
        r_count     <= '0;
        r_load_done <= 1'b0;
        r_error     <= 1'b0;
      end
      if (w_halt_seen) r_load_done <= 1'b1;
      if (w_overflow || w_timeout) begin
        r_error     <= 1'b1;
        r_load_done <= 1'b0;
      end
    end
  end

  assign o_we_IF            = r_we;
  assign o_instruction_data = r_data;
  assign o_halt             = r_halt;
  assign o_pipe_rst         = r_pipe_rst;
  assign o_instr_count      = r_count;
  assign o_load_done        = r_load_done;
  assign o_error            = r_error;
  assign o_state            = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader against a transaction-level model
module tb_instr_loader;

  localparam int NBC = 2;
  localparam int TO  = 20;
  localparam int M_IDLE = 0, M_LOAD = 1, M_WRITE = 2, M_RUN = 3, M_STEP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic           pipe_halted = 1'b0;
  logic           we_if;
  logic [31:0]    instr_data;
  logic           halt;
  logic           pipe_rst;
  logic [NBC-1:0] instr_count;
  logic           load_done;
  logic           error;
  logic [2:0]     state;

  instr_loader #(
    .NB_DATA  (32),
    .NB_COUNT (NBC)
`ifdef LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk                (clk),
    .i_rst              (rst),
    .i_rx_data          (rx_data),
    .i_rx_valid         (rx_valid),
    .i_pipe_halted      (pipe_halted),
    .o_we_IF            (we_if),
    .o_instruction_data (instr_data),
    .o_halt             (halt),
    .o_pipe_rst         (pipe_rst),
    .o_instr_count      (instr_count),
    .o_load_done        (load_done),
    .o_error            (error),
    .o_state            (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue per word and the command rules, evaluated once per edge.
  int          m_mode = M_IDLE;
  logic [7:0]  q[$];
  logic        m_we = 0, m_halt = 1, m_prst = 0, m_done = 0, m_err = 0;
  logic [31:0] m_data = 0;
  int          m_count = 0;
  int          m_stall = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; q.delete(); m_we = 0; m_data = 0; m_halt = 1; m_prst = 0;
      m_count = 0; m_done = 0; m_err = 0; m_stall = 0;
    end else begin
      m_we = 0; m_prst = 0;
      if (m_mode != M_LOAD) m_stall = 0;
      case (m_mode)
        M_IDLE: if (rx_valid) begin
          if (rx_data == 8'h4C) begin
            m_mode = M_LOAD; m_prst = 1; m_count = 0; m_done = 0; m_err = 0; q.delete();
          end else if (rx_data == 8'h52 && m_done) m_mode = M_RUN;
          else if (rx_data == 8'h53 && m_done) m_mode = M_STEP;
        end
        M_LOAD: if (rx_valid) begin
          m_stall = 0;
          q.push_back(rx_data);
          if (q.size() == 4) begin
            m_data  = {q[0], q[1], q[2], q[3]};
            q.delete();
            m_we    = 1;
            m_count = (m_count + 1) % (1 << NBC);
            m_mode  = M_WRITE;
          end
        end else begin
          m_stall++;
`ifdef LOADER_TIMEOUT_EN
          if (m_stall == TO) begin m_mode = M_IDLE; m_err = 1; m_done = 0; q.delete(); end
`endif
        end
        M_WRITE: begin
          if (rx_valid) q.push_back(rx_data);
          if (m_data == 32'hFFFFFFFF) begin m_mode = M_IDLE; m_done = 1; end
          else if (m_count == 0) begin m_mode = M_IDLE; m_err = 1; m_done = 0; end
          else m_mode = M_LOAD;
        end
        M_RUN:  if (pipe_halted) m_mode = M_IDLE;
        M_STEP: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      m_halt = !(m_mode == M_RUN || (m_mode == M_STEP && !pipe_halted));
    end
  end

  bit          cmp_en = 0;
  logic [31:0] wlog[$];
  int          prst_cnt = 0;
  int          halt_low_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state",      32'(state),       32'(m_mode));
      chk("halt",       32'(halt),        32'(m_halt));
      chk("we_IF",      32'(we_if),       32'(m_we));
      chk("instr_data", instr_data,       m_data);
      chk("pipe_rst",   32'(pipe_rst),    32'(m_prst));
      chk("count",      32'(instr_count), 32'(m_count));
      chk("load_done",  32'(load_done),   32'(m_done));
      chk("error",      32'(error),       32'(m_err));
      if (we_if) wlog.push_back(instr_data);
      if (pipe_rst) prst_cnt++;
      if (!halt) halt_low_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) begin
      send(w[i*8 +: 8]);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  int base;

  initial begin
    tick();
    cmp_en = 1;
    tick();
    rst = 1'b0;
    tick();

    // Run before any load is ignored
    send(8'h52); tick();
    chk("lit_idle_halt", 32'(halt), 32'd1);
    chk("lit_idle_state", 32'(state), 32'd0);

    // Spaced-out load of two words
    send(8'h4C);
    send_word(32'h00221820, 1);
    send_word(32'hFFFFFFFF, 1);
    repeat (3) tick();
    chk("lit_load1_nwr", wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      chk("lit_load1_w0", wlog[0], 32'h00221820);
      chk("lit_load1_w1", wlog[1], 32'hFFFFFFFF);
    end
    chk("lit_load1_cnt", 32'(instr_count), 32'd2);
    chk("lit_load1_done", 32'(load_done), 32'd1);
    chk("lit_load1_prst", prst_cnt, 32'd1);

    // Single step: exactly one unfrozen cycle
    halt_low_cnt = 0;
    send(8'h53);
    repeat (4) tick();
    chk("lit_step_low", halt_low_cnt, 32'd1);

    // Continuous run; bytes ignored; halt returns after pipe reports halted
    send(8'h52);
    repeat (4) tick();
    chk("lit_run_halt", 32'(halt), 32'd0);
    send(8'h4C); tick();
    chk("lit_run_state", 32'(state), 32'd3);
    pipe_halted = 1'b1;
    tick();
    pipe_halted = 1'b0;
    chk("lit_run_stop_halt", 32'(halt), 32'd1);
    chk("lit_run_stop_state", 32'(state), 32'd0);
    tick();

    // Back-to-back bytes, including during WRITE; 4th word wraps the counter but is HALT
    base = wlog.size();
    send(8'h4C);
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 0);
    send_word(32'h99AABBCC, 0);
    send_word(32'hFFFFFFFF, 0);
    repeat (3) tick();
    chk("lit_b2b_nwr", wlog.size() - base, 32'd4);
    if (wlog.size() == base + 4) begin
      chk("lit_b2b_w0", wlog[base],   32'h11223344);
      chk("lit_b2b_w1", wlog[base+1], 32'h55667788);
      chk("lit_b2b_w2", wlog[base+2], 32'h99AABBCC);
      chk("lit_b2b_w3", wlog[base+3], 32'hFFFFFFFF);
    end
    chk("lit_b2b_done", 32'(load_done), 32'd1);
    chk("lit_b2b_cnt", 32'(instr_count), 32'd0);

    // Overflow: 2^NB_COUNT non-halt words, command codes treated as data
    base = wlog.size();
    send(8'h4C);
    send_word(32'h4C525300, 0);
    send_word(32'h01020304, 0);
    send_word(32'hA5A5A5A5, 0);
    send_word(32'h12345678, 0);
    repeat (3) tick();
    chk("lit_ovf_nwr", wlog.size() - base, 32'd4);
    if (wlog.size() == base + 4) chk("lit_ovf_w0", wlog[base], 32'h4C525300);
    chk("lit_ovf_err", 32'(error), 32'd1);
    chk("lit_ovf_done", 32'(load_done), 32'd0);
    chk("lit_ovf_state", 32'(state), 32'd0);
    send(8'h53); tick();
    chk("lit_ovf_step_ign", 32'(state), 32'd0);
    chk("lit_ovf_err_sticky", 32'(error), 32'd1);

    // Reset mid-word, coincident with a byte
    base = wlog.size();
    send(8'h4C);
    send(8'hDE); send(8'hAD);
    rst = 1'b1; rx_data = 8'h4C; rx_valid = 1'b1;
    tick();
    rst = 1'b0; rx_valid = 1'b0;
    send(8'hBE); send(8'hEF);
    repeat (2) tick();
    chk("lit_rst_nwr", wlog.size() - base, 32'd0);
    chk("lit_rst_state", 32'(state), 32'd0);
    chk("lit_rst_err", 32'(error), 32'd0);
    chk("lit_rst_halt", 32'(halt), 32'd1);
    chk("lit_rst_data", instr_data, 32'd0);

`ifdef LOADER_TIMEOUT_EN
    base = wlog.size();
    send(8'h4C);
    send(8'h12); send(8'h34);
    repeat (TO + 3) tick();
    chk("lit_to_err", 32'(error), 32'd1);
    chk("lit_to_state", 32'(state), 32'd0);
    chk("lit_to_nwr", wlog.size() - base, 32'd0);
`endif

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Debug-side front end that feeds the MIPS pipeline's instruction-fetch write port and halt control.
- Accepts a byte stream from the UART receiver, which the loader does not own, and decodes command bytes.
- Assembles 4-byte instruction words and pulses o_we_IF to write each word into instruction memory.
- Governs pipeline freeze (o_halt) for idle, run and single-step modes.

Parameters:
- NB_DATA, 32, instruction word width
- NB_BYTE, 8, UART byte width
- NB_COUNT, 8, width of instruction counter (max 2^NB_COUNT words)
- CMD_LOAD, 8'h4C, 'L': enter load mode
- CMD_RUN, 8'h52, 'R': run continuously
- CMD_STEP, 8'h53, 'S': advance one clock
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker word
- TIMEOUT_CYCLES, 1000000, inter-byte timeout (optional feature only)

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_pipe_halted  in  1  pipeline reports HALT_WORD reached WB
- o_we_IF  out  1  instruction-memory write strobe (one cycle per word)
- o_instruction_data  out  NB_DATA  word being written, valid while o_we_IF=1
- o_halt  out  1  1 = pipeline frozen
- o_pipe_rst  out  1  one-cycle pulse clearing pipeline/PC at load start
- o_instr_count  out  NB_COUNT  words written in last/current load
- o_load_done  out  1  level, high after successful load until next CMD_LOAD
- o_error  out  1  sticky overflow/timeout flag, cleared by CMD_LOAD or i_rst
- o_state  out  3  current FSM state (debug)

Behaviour:
- Reset (i_rst=1 at posedge): state=IDLE, o_halt=1, o_we_IF=0, o_instruction_data=0, o_pipe_rst=0, o_instr_count=0, o_load_done=0, o_error=0, byte index=0.
- Reset mid-load or mid-run takes effect at the next edge. A partially assembled word is discarded; no write occurs.
- FSM states: IDLE(0), LOAD(1), WRITE(2), RUN(3), STEP(4).
- IDLE: o_halt=1. Byte handling:
  - CMD_LOAD -> LOAD; same cycle: o_pipe_rst pulses 1 cycle, counter=0, byte index=0, o_load_done=0, o_error=0.
  - CMD_RUN -> RUN, only if o_load_done=1; otherwise ignored.
  - CMD_STEP -> STEP, only if o_load_done=1; otherwise ignored.
  - Any other byte is ignored.
- LOAD: o_halt=1.
  - Each i_rx_valid shifts the byte in, big-endian: first byte -> bits 31:24.
  - On the 4th byte -> WRITE with the full word registered.
  - Command bytes are not decoded in LOAD; all bytes are data.
- WRITE, exactly one cycle:
  - o_we_IF=1 with o_instruction_data = word; counter increments.
  - If word==HALT_WORD -> IDLE with o_load_done=1.
  - Else if counter wraps to 0 (2^NB_COUNT words written) -> IDLE with o_error=1, o_load_done=0.
  - Else -> LOAD.
  - An i_rx_valid arriving during WRITE is captured as byte 0 of the next word; no byte loss.
- o_we_IF is registered and never high outside WRITE. o_instruction_data holds its last value otherwise.
- RUN: o_halt=0 from the cycle after entry.
  - When i_pipe_halted=1 -> IDLE, o_halt=1 on the next cycle.
  - Bytes are ignored during RUN.
- STEP: o_halt=0 for exactly one cycle, then -> IDLE.
  - If i_pipe_halted=1 on entry, stay halted and return to IDLE.
- Simultaneous i_rst and i_rx_valid: reset wins.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: a cycle counter runs in LOAD and resets on each i_rx_valid. After TIMEOUT_CYCLES cycles with no byte -> IDLE, o_error=1, partial word discarded, no write.
- Not defined: LOAD waits indefinitely; no counter logic is synthesised.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - state encoding (IDLE..STEP)
  - CMD_LOAD/CMD_RUN/CMD_STEP
  - HALT_WORD
  - NB_BYTE
- One sub-module, word_assembler: byte shift register + 2-bit index, outputs word and word_valid; reused by future data-dump path.

Test Plan:
- Reset, send 'R' -> ignored: o_halt stays 1, state IDLE.
- Send 'L', bytes 00 22 18 20 FF FF FF FF -> o_pipe_rst pulse; o_we_IF pulses twice with 32'h00221820 then 32'hFFFFFFFF; o_instr_count=2; o_load_done=1.
- After load, 'S' -> o_halt low exactly 1 cycle. Then 'R' -> o_halt low until i_pipe_halted=1, high next cycle.
- Back-to-back bytes every cycle (incl. during WRITE) for 3 words + HALT_WORD -> 4 correct writes, no dropped byte.
- NB_COUNT=2, load 4 non-halt words -> o_error=1, o_load_done=0, IDLE after 4th write.
- i_rst asserted after 2 bytes of a word -> no o_we_IF; all outputs at reset values. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=20, stall 20 cycles mid-word -> o_error=1, IDLE.
